// File: rtl/module_branch_predictor.sv
// rtl/module_branch_predictor.sv - direct-mapped BTB with 2-bit counters and branch statistics
module module_branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] PCF_i,
  output logic        PredTakenF_o,
  output logic [31:0] PredTargetF_o,
  input  logic        WE_BTB_i,
  input  logic [31:0] PCE_i,
  input  logic        TakenE_i,
  input  logic [31:0] TargetE_i,
  input  logic        PredTakenE_i,
  input  logic [31:0] PredTargetE_i,
  output logic        MispredictE_o,
  output logic [31:0] BranchCount_o,
  output logic [31:0] MispredCount_o
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  // Table storage: one valid/tag/target/counter per entry
  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, hit_e;
  logic [1:0]      ctr_e, ctr_upd_d;

  // Byte-offset bits never participate in index or tag
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

  assign idx_f = PCF_i[IDXW+1:2];
  assign tag_f = PCF_i[31:IDXW+2];
  assign idx_e = PCE_i[IDXW+1:2];
  assign tag_e = PCE_i[31:IDXW+2];

  // Fetch lookup reads registered contents only, so a same-cycle write is not visible
  always_comb begin
    hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF_o  = hit_f && ctr_q[idx_f][1];
    PredTargetF_o = PredTakenF_o ? target_q[idx_f] : 32'h0;
  end

  // Execute-stage misprediction: wrong direction, or taken with the wrong target
  always_comb begin
    MispredictE_o = WE_BTB_i &&
                    ((PredTakenE_i != TakenE_i) ||
                     (PredTakenE_i && TakenE_i && (PredTargetE_i != TargetE_i)));
  end

  // Saturating counter step for the entry being resolved
  always_comb begin
    hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_e     = ctr_q[idx_e];
    ctr_upd_d = ctr_e;
    if (TakenE_i) begin
      if (ctr_e != 2'b11) ctr_upd_d = ctr_e + 2'b01;
    end else begin
      if (ctr_e != 2'b00) ctr_upd_d = ctr_e - 2'b01;
    end
  end

  // Saturating statistics next-state
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (WE_BTB_i && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (MispredictE_o && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Table and statistics update; reset wins over any concurrent resolution
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= 32'h0;
      mispred_cnt_q <= 32'h0;
    end else if (WE_BTB_i) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_upd_d;
        if (TakenE_i) target_q[idx_e] <= TargetE_i;
      end else if (TakenE_i) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= TargetE_i;
        ctr_q[idx_e]    <= 2'b10;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount_o  = branch_cnt_q;
  assign MispredCount_o = mispred_cnt_q;

endmodule
